// File: rtl/handshake_if.sv
// Bundled valid/ready bus for NUM_CH independent channels (data, addr, read_write).
// The checker only observes the bus, so it connects through the monitor modport.
interface handshake_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_rw;

  modport master  (output ch_valid, ch_data, ch_addr, ch_rw, input ch_ready);
  modport slave   (input ch_valid, ch_data, ch_addr, ch_rw, output ch_ready);
  modport monitor (input ch_valid, ch_ready, ch_data, ch_addr, ch_rw);
endinterface

// File: rtl/handshake_checker.sv
// Passive per-channel valid/ready protocol checker: timeout, payload stability and
// early-drop detection, plus saturating transaction counts and stall high-water marks.
module handshake_checker #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 10,
  parameter int WAIT_W   = 8,
  parameter int COUNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  handshake_if.monitor              bus,
  input  logic [NUM_CH-1:0]         clr_err,
  input  logic [NUM_CH-1:0]         clr_cnt,
  output logic [NUM_CH-1:0]         err_timeout,
  output logic [NUM_CH-1:0]         err_unstable,
  output logic [NUM_CH-1:0]         err_drop,
  output logic [NUM_CH*COUNT_W-1:0] txn_count,
  output logic [NUM_CH*WAIT_W-1:0]  max_wait,
  output logic                      err_any
);
  localparam int PAY_W = DATA_W + ADDR_W + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TIMEOUT} state_t;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t              state_reg;
      logic [PAY_W-1:0]    cap_reg;
      logic [WAIT_W-1:0]   wait_cnt_reg;
      logic [WAIT_W-1:0]   max_wait_reg;
      logic [COUNT_W-1:0]  txn_count_reg;
      logic                err_timeout_reg;
      logic                err_unstable_reg;
      logic                err_drop_reg;

      logic                valid;
      logic                fire;
      logic                stall;
      logic [PAY_W-1:0]    live;
      logic [COUNT_W-1:0]  txn_base;
      logic [WAIT_W-1:0]   max_base;
      logic [WAIT_W-1:0]   stall_len;

      assign valid = bus.ch_valid[gi];
      assign fire  = valid & bus.ch_ready[gi];
      assign stall = valid & ~bus.ch_ready[gi];
      assign live  = {bus.ch_data[gi*DATA_W +: DATA_W], bus.ch_addr[gi*ADDR_W +: ADDR_W], bus.ch_rw[gi]};

      // A counter clear folds into the base so a coincident fire lands on top of zero.
      assign txn_base  = clr_cnt[gi] ? '0 : txn_count_reg;
      assign max_base  = clr_cnt[gi] ? '0 : max_wait_reg;
      assign stall_len = (state_reg == ST_IDLE) ? '0 : wait_cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg        <= ST_IDLE;
          cap_reg          <= '0;
          wait_cnt_reg     <= '0;
          max_wait_reg     <= '0;
          txn_count_reg    <= '0;
          err_timeout_reg  <= 1'b0;
          err_unstable_reg <= 1'b0;
          err_drop_reg     <= 1'b0;
        end else begin
          // Clears come first so any set later in this block overrides them.
          if (clr_err[gi]) begin
            err_timeout_reg  <= 1'b0;
            err_unstable_reg <= 1'b0;
            err_drop_reg     <= 1'b0;
          end
          txn_count_reg <= txn_base;
          max_wait_reg  <= max_base;

          if (!enable) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
          end else begin
            if (state_reg != ST_IDLE && valid && live != cap_reg) begin
              err_unstable_reg <= 1'b1;
              cap_reg          <= live;
            end
            if (fire) begin
              txn_count_reg <= (&txn_base) ? txn_base : txn_base + COUNT_W'(1);
              max_wait_reg  <= (stall_len > max_base) ? stall_len : max_base;
              wait_cnt_reg  <= '0;
              state_reg     <= ST_IDLE;
            end else if (stall) begin
              if (state_reg == ST_IDLE) begin
                cap_reg      <= live;
                wait_cnt_reg <= WAIT_W'(1);
                state_reg    <= ST_WAIT;
              end else begin
                if (!(&wait_cnt_reg))
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                if (state_reg == ST_WAIT && wait_cnt_reg == WAIT_LIMIT) begin
                  err_timeout_reg <= 1'b1;
                  state_reg       <= ST_TIMEOUT;
                end
              end
            end else if (state_reg != ST_IDLE) begin
              err_drop_reg <= 1'b1;
              wait_cnt_reg <= '0;
              state_reg    <= ST_IDLE;
            end
          end
        end
      end

      assign err_timeout[gi]                  = err_timeout_reg;
      assign err_unstable[gi]                 = err_unstable_reg;
      assign err_drop[gi]                     = err_drop_reg;
      assign txn_count[gi*COUNT_W +: COUNT_W] = txn_count_reg;
      assign max_wait[gi*WAIT_W +: WAIT_W]    = max_wait_reg;
    end
  endgenerate

  assign err_any = |{err_timeout, err_unstable, err_drop};
endmodule

// File: tb/tb_handshake_checker.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_handshake_checker;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int MAX_WAIT = 10;
  localparam int WAIT_W   = 8;
  localparam int COUNT_W  = 4;
  localparam int PAY_W    = DATA_W + ADDR_W + 1;
  localparam int CNT_MAX  = (1 << COUNT_W) - 1;
  localparam int WAIT_SAT = (1 << WAIT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [NUM_CH-1:0]         clr_err;
  logic [NUM_CH-1:0]         clr_cnt;
  logic [NUM_CH-1:0]         err_timeout;
  logic [NUM_CH-1:0]         err_unstable;
  logic [NUM_CH-1:0]         err_drop;
  logic [NUM_CH*COUNT_W-1:0] txn_count;
  logic [NUM_CH*WAIT_W-1:0]  max_wait;
  logic                      err_any;

  int n_checks = 0;
  int n_fail   = 0;

  handshake_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  handshake_checker #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .clr_err(clr_err), .clr_cnt(clr_cnt),
    .err_timeout(err_timeout), .err_unstable(err_unstable), .err_drop(err_drop),
    .txn_count(txn_count), .max_wait(max_wait), .err_any(err_any)
  );

  always #5 clk = ~clk;

  // Reference model: a channel is either idle or holding a pending offer of known age.
  bit               m_pend [NUM_CH];
  int               m_stall[NUM_CH];
  logic [PAY_W-1:0] m_cap  [NUM_CH];
  bit               m_to   [NUM_CH];
  bit               m_un   [NUM_CH];
  bit               m_dr   [NUM_CH];
  int               m_cnt  [NUM_CH];
  int               m_max  [NUM_CH];

  function automatic logic [PAY_W-1:0] live_pay(int c);
    return {bus.ch_data[c*DATA_W +: DATA_W], bus.ch_addr[c*ADDR_W +: ADDR_W], bus.ch_rw[c]};
  endfunction

  function automatic int dut_cnt(int c);
    return int'(txn_count[c*COUNT_W +: COUNT_W]);
  endfunction

  function automatic int dut_max(int c);
    return int'(max_wait[c*WAIT_W +: WAIT_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pend[c] = 0; m_stall[c] = 0; m_cap[c] = '0;
      m_to[c] = 0; m_un[c] = 0; m_dr[c] = 0; m_cnt[c] = 0; m_max[c] = 0;
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NUM_CH; c++) begin
      bit v, r, s_to, s_un, s_dr;
      logic [PAY_W-1:0] p;
      int cnt, mx, len;
      v = bus.ch_valid[c];
      r = bus.ch_ready[c];
      p = live_pay(c);
      s_to = 0; s_un = 0; s_dr = 0;
      cnt = clr_cnt[c] ? 0 : m_cnt[c];
      mx  = clr_cnt[c] ? 0 : m_max[c];
      if (!enable) begin
        m_pend[c] = 0; m_stall[c] = 0;
      end else if (m_pend[c]) begin
        if (v && p !== m_cap[c]) begin s_un = 1; m_cap[c] = p; end
        if (v && r) begin
          cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
          len = (m_stall[c] > WAIT_SAT) ? WAIT_SAT : m_stall[c];
          if (len > mx) mx = len;
          m_pend[c] = 0; m_stall[c] = 0;
        end else if (v) begin
          m_stall[c] = m_stall[c] + 1;
          if (m_stall[c] == MAX_WAIT + 1) s_to = 1;
        end else begin
          s_dr = 1; m_pend[c] = 0; m_stall[c] = 0;
        end
      end else if (v && r) begin
        cnt = (cnt < CNT_MAX) ? cnt + 1 : CNT_MAX;
      end else if (v) begin
        m_pend[c] = 1; m_stall[c] = 1; m_cap[c] = p;
      end
      if (clr_err[c]) begin m_to[c] = 0; m_un[c] = 0; m_dr[c] = 0; end
      m_to[c] = m_to[c] | s_to;
      m_un[c] = m_un[c] | s_un;
      m_dr[c] = m_dr[c] | s_dr;
      m_cnt[c] = cnt;
      m_max[c] = mx;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_all();
    bus.ch_valid = '0; bus.ch_ready = '0; clr_err = '0; clr_cnt = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; idle_all();
    bus.ch_data = '0; bus.ch_addr = '0; bus.ch_rw = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (err_timeout !== '0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", err_timeout); end
    n_checks++; if (err_unstable !== '0) begin n_fail++; $display("FAIL reset_unstable: got %b want 0", err_unstable); end
    n_checks++; if (err_drop !== '0) begin n_fail++; $display("FAIL reset_drop: got %b want 0", err_drop); end
    n_checks++; if (txn_count !== '0) begin n_fail++; $display("FAIL reset_txn_count: got %h want 0", txn_count); end
    n_checks++; if (max_wait !== '0) begin n_fail++; $display("FAIL reset_max_wait: got %h want 0", max_wait); end
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL reset_err_any: got %b want 0", err_any); end
    #2 reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    bus.ch_valid[0] = 1'b1; bus.ch_ready[0] = 1'b1;
    repeat (3) tick();
    idle_all();
    tick();
    n_checks++; if (dut_cnt(0) !== 3) begin n_fail++; $display("FAIL b2b_txn_count: got %0d want 3", dut_cnt(0)); end
    n_checks++; if (dut_max(0) !== 0) begin n_fail++; $display("FAIL b2b_max_wait: got %0d want 0", dut_max(0)); end
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL b2b_err_any: got %b want 0", err_any); end
    $display("test_back_to_back done");
  endtask

  task automatic test_timeout();
    bus.ch_valid[1] = 1'b1; bus.ch_ready[1] = 1'b0;
    repeat (MAX_WAIT) tick();
    bus.ch_ready[1] = 1'b1;
    tick();
    n_checks++; if (err_timeout[1] !== 1'b0) begin n_fail++; $display("FAIL to_limit_flag: got %b want 0", err_timeout[1]); end
    n_checks++; if (dut_max(1) !== MAX_WAIT) begin n_fail++; $display("FAIL to_limit_max_wait: got %0d want %0d", dut_max(1), MAX_WAIT); end
    bus.ch_ready[1] = 1'b0;
    repeat (MAX_WAIT) tick();
    n_checks++; if (err_timeout[1] !== 1'b0) begin n_fail++; $display("FAIL to_early_flag: got %b want 0", err_timeout[1]); end
    tick();
    n_checks++; if (err_timeout[1] !== 1'b1) begin n_fail++; $display("FAIL to_over_flag: got %b want 1", err_timeout[1]); end
    n_checks++; if (err_any !== 1'b1) begin n_fail++; $display("FAIL to_err_any: got %b want 1", err_any); end
    bus.ch_ready[1] = 1'b1;
    tick();
    n_checks++; if (dut_cnt(1) !== 2) begin n_fail++; $display("FAIL to_txn_count: got %0d want 2", dut_cnt(1)); end
    n_checks++; if (dut_max(1) !== MAX_WAIT + 1) begin n_fail++; $display("FAIL to_max_wait: got %0d want %0d", dut_max(1), MAX_WAIT + 1); end
    idle_all();
    clr_err[1] = 1'b1;
    tick();
    clr_err = '0;
    n_checks++; if (err_timeout[1] !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b want 0", err_timeout[1]); end
    $display("test_timeout done");
  endtask

  task automatic test_unstable();
    bus.ch_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
    bus.ch_valid[2] = 1'b1; bus.ch_ready[2] = 1'b0;
    repeat (2) tick();
    n_checks++; if (err_unstable[2] !== 1'b0) begin n_fail++; $display("FAIL unst_early: got %b want 0", err_unstable[2]); end
    bus.ch_data[2*DATA_W +: DATA_W] = 32'hDEADBEEE;
    tick();
    n_checks++; if (err_unstable[2] !== 1'b1) begin n_fail++; $display("FAIL unst_flag: got %b want 1", err_unstable[2]); end
    bus.ch_ready[2] = 1'b1;
    tick();
    n_checks++; if (dut_cnt(2) !== 1) begin n_fail++; $display("FAIL unst_txn_count: got %0d want 1", dut_cnt(2)); end
    idle_all();
    clr_err[2] = 1'b1;
    tick();
    clr_err = '0;
    n_checks++; if (err_unstable[2] !== 1'b0) begin n_fail++; $display("FAIL unst_clear: got %b want 0", err_unstable[2]); end
    $display("test_unstable done");
  endtask

  task automatic test_drop();
    bus.ch_valid[3] = 1'b1; bus.ch_ready[3] = 1'b0;
    repeat (4) tick();
    bus.ch_valid[3] = 1'b0;
    clr_err[3] = 1'b1;
    tick();
    clr_err = '0;
    n_checks++; if (err_drop[3] !== 1'b1) begin n_fail++; $display("FAIL drop_flag: got %b want 1", err_drop[3]); end
    n_checks++; if (dut_cnt(3) !== 0) begin n_fail++; $display("FAIL drop_txn_count: got %0d want 0", dut_cnt(3)); end
    bus.ch_valid[3] = 1'b1; bus.ch_ready[3] = 1'b1;
    tick();
    n_checks++; if (dut_max(3) !== 0) begin n_fail++; $display("FAIL drop_idle_max_wait: got %0d want 0", dut_max(3)); end
    n_checks++; if (dut_cnt(3) !== 1) begin n_fail++; $display("FAIL drop_idle_txn: got %0d want 1", dut_cnt(3)); end
    idle_all();
    clr_err[3] = 1'b1;
    tick();
    clr_err = '0;
    n_checks++; if (err_drop[3] !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b want 0", err_drop[3]); end
    $display("test_drop done");
  endtask

  task automatic test_saturation();
    bus.ch_valid[0] = 1'b1; bus.ch_ready[0] = 1'b1;
    repeat (CNT_MAX - 3) tick();
    n_checks++; if (dut_cnt(0) !== CNT_MAX) begin n_fail++; $display("FAIL sat_reach: got %0d want %0d", dut_cnt(0), CNT_MAX); end
    repeat (2) tick();
    n_checks++; if (dut_cnt(0) !== CNT_MAX) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", dut_cnt(0), CNT_MAX); end
    bus.ch_ready[0] = 1'b0;
    repeat (3) tick();
    bus.ch_ready[0] = 1'b1; clr_cnt[0] = 1'b1;
    tick();
    idle_all();
    n_checks++; if (dut_cnt(0) !== 1) begin n_fail++; $display("FAIL sat_clr_fire_txn: got %0d want 1", dut_cnt(0)); end
    n_checks++; if (dut_max(0) !== 3) begin n_fail++; $display("FAIL sat_clr_fire_max: got %0d want 3", dut_max(0)); end
    $display("test_saturation done");
  endtask

  task automatic test_async_reset();
    bus.ch_valid = '1; bus.ch_ready = '0;
    repeat (5) tick();
    #3 reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (txn_count !== '0) begin n_fail++; $display("FAIL areset_txn_count: got %h want 0", txn_count); end
    n_checks++; if (max_wait !== '0) begin n_fail++; $display("FAIL areset_max_wait: got %h want 0", max_wait); end
    n_checks++; if ({err_timeout, err_unstable, err_drop, err_any} !== '0) begin
      n_fail++; $display("FAIL areset_flags: got %b want 0", {err_timeout, err_unstable, err_drop, err_any});
    end
    #1 reset = 1'b1;
    repeat (MAX_WAIT) tick();
    bus.ch_ready = '1;
    tick();
    idle_all();
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL areset_stall_err: got %b want 0", err_any); end
    for (int c = 0; c < NUM_CH; c++) begin
      n_checks++; if (dut_max(c) !== MAX_WAIT) begin n_fail++; $display("FAIL areset_max_ch%0d: got %0d want %0d", c, dut_max(c), MAX_WAIT); end
      n_checks++; if (dut_cnt(c) !== 1) begin n_fail++; $display("FAIL areset_txn_ch%0d: got %0d want 1", c, dut_cnt(c)); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_enable();
    bus.ch_valid[2] = 1'b1; bus.ch_ready[2] = 1'b0;
    repeat (3) tick();
    enable = 1'b0; clr_cnt[2] = 1'b1;
    tick();
    clr_cnt = '0;
    tick();
    n_checks++; if (dut_cnt(2) !== 0) begin n_fail++; $display("FAIL en_clr_cnt: got %0d want 0", dut_cnt(2)); end
    n_checks++; if (err_any !== 1'b0) begin n_fail++; $display("FAIL en_no_flag: got %b want 0", err_any); end
    enable = 1'b1; bus.ch_ready[2] = 1'b1;
    tick();
    idle_all();
    n_checks++; if (dut_max(2) !== 0) begin n_fail++; $display("FAIL en_forced_idle: got %0d want 0", dut_max(2)); end
    n_checks++; if (dut_cnt(2) !== 1) begin n_fail++; $display("FAIL en_txn: got %0d want 1", dut_cnt(2)); end
    $display("test_enable done");
  endtask

  task automatic test_random();
    int rp;
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rp = (c == 0) ? 1 : (c == 1) ? 3 : (c == 2) ? 8 : 14;
        if ($urandom_range(0, 19) == 0) begin
          bus.ch_data[c*DATA_W +: DATA_W] = $urandom;
          bus.ch_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          bus.ch_rw[c] = 1'($urandom);
        end
        bus.ch_valid[c] = ($urandom_range(0, 9) != 0);
        bus.ch_ready[c] = ($urandom_range(0, rp) == 0);
        clr_err[c] = ($urandom_range(0, 29) == 0);
        clr_cnt[c] = ($urandom_range(0, 39) == 0);
      end
      enable = ($urandom_range(0, 49) != 0);
      tick();
      for (int c = 0; c < NUM_CH; c++) begin
        n_checks++; if (err_timeout[c] !== m_to[c]) begin n_fail++; $display("FAIL rnd_timeout c%0d n%0d: got %b want %b", c, n, err_timeout[c], m_to[c]); end
        n_checks++; if (err_unstable[c] !== m_un[c]) begin n_fail++; $display("FAIL rnd_unstable c%0d n%0d: got %b want %b", c, n, err_unstable[c], m_un[c]); end
        n_checks++; if (err_drop[c] !== m_dr[c]) begin n_fail++; $display("FAIL rnd_drop c%0d n%0d: got %b want %b", c, n, err_drop[c], m_dr[c]); end
        n_checks++; if (dut_cnt(c) !== m_cnt[c]) begin n_fail++; $display("FAIL rnd_txn c%0d n%0d: got %0d want %0d", c, n, dut_cnt(c), m_cnt[c]); end
        n_checks++; if (dut_max(c) !== m_max[c]) begin n_fail++; $display("FAIL rnd_max c%0d n%0d: got %0d want %0d", c, n, dut_max(c), m_max[c]); end
      end
      n_checks++;
      if (err_any !== (|{m_to.or(), m_un.or(), m_dr.or()})) begin
        n_fail++; $display("FAIL rnd_err_any n%0d: got %b", n, err_any);
      end
    end
    idle_all();
    enable = 1'b1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_timeout();
    test_unstable();
    test_drop();
    test_saturation();
    test_async_reset();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
